// File: rtl/ce_pkt_tx_pkg.sv
// Shared types for the channel-estimation packet transmitter: length type,
// writer state encoding and data-buffer entry layout.
package ce_pkt_tx_pkg;

  localparam int unsigned LEN_W = 12;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  // Entry layout is {sop, eop, real, imag}; control bits sit above the 2*wData sample bits.
  localparam int unsigned ENT_EOP_OFS = 0;
  localparam int unsigned ENT_SOP_OFS = 1;
  localparam int unsigned ENT_CTRL_W  = 2;

  function automatic int unsigned ent_width(input int unsigned w_data);
    return 2 * w_data + ENT_CTRL_W;
  endfunction

endpackage

// File: rtl/ce_sync_fifo.sv
// Single-clock FIFO with registered RAM read: o_rd_data updates the cycle after
// an accepted i_rd_en and holds otherwise.
module ce_sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n_sync,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_rd_data;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = i_wr_en && (r_count != FULL_CNT);
  assign w_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/ce_pkt_tx.sv
// Buffers whole input frames and re-emits them as sop/eop-framed Avalon-ST
// packets under backpressure; frames that cannot be reserved are dropped whole.
module ce_pkt_tx
  import ce_pkt_tx_pkg::*;
#(
  parameter int unsigned wData    = 16,
  parameter int unsigned wAddr    = 11,
  parameter int unsigned wLenAddr = 2
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic [wData-1:0] in_real,
  input  logic [wData-1:0] in_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out,
  output logic             overflow
);

  localparam int unsigned DEPTH   = 1 << wAddr;
  localparam int unsigned EW      = ent_width(wData);
  localparam int unsigned SOP_BIT = 2 * wData + ENT_SOP_OFS;
  localparam int unsigned EOP_BIT = 2 * wData + ENT_EOP_OFS;

  wr_state_e          r_state;
  wr_state_e          w_state_nxt;
  len_t               r_cnt;
  len_t               w_cnt_nxt;
  len_t               r_len;
  len_t               w_len_nxt;
  logic               r_overflow;
  logic               w_ovf;
  logic               w_wr_en;
  logic               w_len_push;
  logic               w_len_bad;
  logic               w_fits;
  logic [EW-1:0]      w_wr_data;
  logic [EW-1:0]      w_rd_data;
  logic [wAddr:0]     w_dcount;
  logic               w_dfull;
  logic               w_dempty;
  len_t               w_len_rd;
  logic [wLenAddr:0]  w_lcount;
  logic               w_lfull;
  logic               w_lempty;
  logic               w_unused;

  logic               r_s1_vld;
  logic               r_src_valid;
  logic               r_src_sop;
  logic               r_src_eop;
  logic [wData-1:0]   r_src_real;
  logic [wData-1:0]   r_src_imag;
  logic               r_l1_vld;
  logic               r_lh_vld;
  len_t               r_fftpts_out;
  logic               w_s2_load;
  logic               w_s1_move;
  logic               w_s1_pop;
  logic               w_hs_eop;
  logic               w_lh_load;
  logic               w_l1_move;
  logic               w_l1_pop;

  assign w_unused = ^{w_dfull, w_lcount};

  // Space check counts only what the reader has freed; the admitted frame reserves its own room.
  assign w_len_bad = (fftpts_in == '0) || (32'(fftpts_in) > DEPTH);
  assign w_fits    = ((32'(w_dcount) + 32'(fftpts_in)) <= DEPTH) && !w_lfull;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_wr_en     = 1'b0;
    w_len_push  = 1'b0;
    w_ovf       = 1'b0;
    w_wr_data   = '0;
    w_wr_data[2*wData-1:wData] = in_real;
    w_wr_data[wData-1:0]       = in_imag;
    case (r_state)
      ST_HUNT: begin
        if (in_valid && in_start && !w_len_bad) begin
          w_len_nxt = len_t'(fftpts_in);
          w_cnt_nxt = len_t'(1);
          if (w_fits) begin
            w_wr_en             = 1'b1;
            w_len_push          = 1'b1;
            w_wr_data[SOP_BIT]  = 1'b1;
            if (fftpts_in == 12'd1) begin
              w_wr_data[EOP_BIT] = 1'b1;
            end else begin
              w_state_nxt = ST_WRITE;
            end
          end else begin
            w_ovf = 1'b1;
            if (fftpts_in != 12'd1) begin
              w_state_nxt = ST_DROP;
            end
          end
        end
      end
      ST_WRITE: begin
        if (in_valid) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + len_t'(1);
          if (r_cnt == r_len - len_t'(1)) begin
            w_wr_data[EOP_BIT] = 1'b1;
            w_state_nxt        = ST_HUNT;
          end
        end
      end
      ST_DROP: begin
        if (in_valid) begin
          w_cnt_nxt = r_cnt + len_t'(1);
          if (r_cnt == r_len - len_t'(1)) begin
            w_state_nxt = ST_HUNT;
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      r_state    <= ST_HUNT;
      r_cnt      <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_overflow <= w_ovf;
    end
  end

  ce_sync_fifo #(.W(EW), .AW(wAddr)) u_data_fifo (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_wr_data),
    .i_rd_en    (w_s1_pop),
    .o_rd_data  (w_rd_data),
    .o_count    (w_dcount),
    .o_full     (w_dfull),
    .o_empty    (w_dempty)
  );

  ce_sync_fifo #(.W(LEN_W), .AW(wLenAddr)) u_len_fifo (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .i_wr_en    (w_len_push),
    .i_wr_data  (len_t'(fftpts_in)),
    .i_rd_en    (w_l1_pop),
    .o_rd_data  (w_len_rd),
    .o_count    (w_lcount),
    .o_full     (w_lfull),
    .o_empty    (w_lempty)
  );

  // Stage 1 is the FIFO read register, stage 2 the output register; pop only when stage 1 frees up.
  assign w_s2_load = !r_src_valid || source_ready;
  assign w_s1_move = r_s1_vld && w_s2_load;
  assign w_s1_pop  = (!r_s1_vld || w_s1_move) && !w_dempty;

  // Length head mirrors the data path so fftpts_out switches right after the eop handshake.
  assign w_hs_eop  = r_src_valid && source_ready && r_src_eop;
  assign w_lh_load = !r_lh_vld || w_hs_eop;
  assign w_l1_move = r_l1_vld && w_lh_load;
  assign w_l1_pop  = (!r_l1_vld || w_l1_move) && !w_lempty;

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      r_s1_vld     <= 1'b0;
      r_src_valid  <= 1'b0;
      r_src_sop    <= 1'b0;
      r_src_eop    <= 1'b0;
      r_src_real   <= '0;
      r_src_imag   <= '0;
      r_l1_vld     <= 1'b0;
      r_lh_vld     <= 1'b0;
      r_fftpts_out <= '0;
    end else begin
      if (w_s1_pop) begin
        r_s1_vld <= 1'b1;
      end else if (w_s1_move) begin
        r_s1_vld <= 1'b0;
      end
      if (w_s2_load) begin
        r_src_valid <= r_s1_vld;
        if (r_s1_vld) begin
          r_src_sop  <= w_rd_data[SOP_BIT];
          r_src_eop  <= w_rd_data[EOP_BIT];
          r_src_real <= w_rd_data[2*wData-1:wData];
          r_src_imag <= w_rd_data[wData-1:0];
        end
      end
      if (w_l1_pop) begin
        r_l1_vld <= 1'b1;
      end else if (w_l1_move) begin
        r_l1_vld <= 1'b0;
      end
      if (w_lh_load) begin
        r_lh_vld     <= r_l1_vld;
        r_fftpts_out <= r_l1_vld ? w_len_rd : '0;
      end
    end
  end

  assign source_valid = r_src_valid;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;
  assign source_real  = r_src_real;
  assign source_imag  = r_src_imag;
  assign source_error = 2'b00;
  assign fftpts_out   = r_fftpts_out;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_ce_pkt_tx.sv
// Scoreboard bench for ce_pkt_tx: drivers push expected beats, a negedge
// monitor compares every presented beat against the queue head.
module tb_ce_pkt_tx;

  logic        clk = 1'b0;
  logic        rst_n_sync;
  logic        in_valid;
  logic        in_start;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic [11:0] fftpts_in;
  logic        source_valid;
  logic        source_ready;
  logic [1:0]  source_error;
  logic        source_sop;
  logic        source_eop;
  logic [15:0] source_real;
  logic [15:0] source_imag;
  logic [11:0] fftpts_out;
  logic        overflow;

  always #5 clk = ~clk;

  ce_pkt_tx #(.wData(16), .wAddr(4), .wLenAddr(2)) dut (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .in_valid     (in_valid),
    .in_start     (in_start),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_error (source_error),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out),
    .overflow     (overflow)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] re;
    logic [15:0] im;
    logic [11:0] len;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    hs_cnt   = 0;
  int    ovf_cnt  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every presented beat must match the queue head, including on stalled cycles.
  always @(negedge clk) begin
    beat_t got;
    if (rst_n_sync) begin
      if (overflow) ovf_cnt++;
      if (source_valid) begin
        got = {source_sop, source_eop, source_real, source_imag, fftpts_out};
        check("source_error", 64'(source_error), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got 0x%0h with no beat expected at %0t", got, $time);
        end else begin
          check("beat", 64'(got), 64'(exp_q[0]));
          if (source_ready) void'(exp_q.pop_front());
        end
        if (source_ready) hs_cnt++;
      end
    end
  end

  task automatic drive(input logic st, input logic [15:0] re, input logic [15:0] im,
                       input logic [11:0] len);
    in_valid  = 1'b1;
    in_start  = st;
    in_real   = re;
    in_imag   = im;
    fftpts_in = len;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_start  = 1'b0;
  endtask

  task automatic frame(input int n, input logic [11:0] len, input logic [15:0] base,
                       input bit admit, input int mid_start, input bit chk_lat);
    beat_t       b;
    logic [15:0] re;
    for (int i = 0; i < n; i++) begin
      re    = base + 16'(i);
      b.sop = (i == 0);
      b.eop = (i == n - 1);
      b.re  = re;
      b.im  = ~re;
      b.len = len;
      if (admit) exp_q.push_back(b);
      drive((i == 0) || (i == mid_start), re, ~re, len);
      if (chk_lat && i == 1) check("latency_k1", 64'(source_valid), 64'd0);
      if (chk_lat && i == 2) check("latency_k2", 64'(source_valid), 64'd1);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"},  64'(source_valid), 64'd0);
    check({pfx, "_sop"},    64'(source_sop),   64'd0);
    check({pfx, "_eop"},    64'(source_eop),   64'd0);
    check({pfx, "_real"},   64'(source_real),  64'd0);
    check({pfx, "_imag"},   64'(source_imag),  64'd0);
    check({pfx, "_fftpts"}, 64'(fftpts_out),   64'd0);
    check({pfx, "_ovf"},    64'(overflow),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int o0;
    beat_t b;
    rst_n_sync   = 1'b0;
    in_valid     = 1'b0;
    in_start     = 1'b0;
    in_real      = '0;
    in_imag      = '0;
    fftpts_in    = '0;
    source_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_err", 64'(source_error), 64'd0);
    rst_n_sync = 1'b1;
    @(posedge clk); #1;

    // Single 8-point frame, latency and ordering
    h0 = hs_cnt;
    frame(8, 12'd8, 16'h1000, 1'b1, -1, 1'b1);
    drain("t1_drain", 100);
    check("t1_beats", 64'(hs_cnt - h0), 64'd8);

    // Same frame under alternating ready
    h0 = hs_cnt;
    fork
      frame(8, 12'd8, 16'h2000, 1'b1, -1, 1'b0);
      begin
        for (int i = 0; i < 40; i++) begin
          source_ready = (i % 2 == 0);
          @(posedge clk); #1;
        end
        source_ready = 1'b1;
      end
    join
    drain("t2_drain", 100);
    check("t2_beats", 64'(hs_cnt - h0), 64'd8);

    // Unaligned samples, then a frame carrying a mid-frame in_start as data
    h0 = hs_cnt;
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h3000 + 16'(i), 16'h0, 12'd4);
    frame(4, 12'd4, 16'h3100, 1'b1, 2, 1'b0);
    drain("t3_drain", 100);
    check("t3_beats", 64'(hs_cnt - h0), 64'd4);

    // Overflow: two frames fit in a 16-entry buffer, the third is dropped
    h0 = hs_cnt;
    o0 = ovf_cnt;
    source_ready = 1'b0;
    frame(8, 12'd8, 16'h4000, 1'b1, -1, 1'b0);
    frame(8, 12'd8, 16'h4100, 1'b1, -1, 1'b0);
    drive(1'b1, 16'h4200, 16'h0, 12'd8);
    check("ovf_pulse", 64'(overflow), 64'd1);
    drive(1'b0, 16'h4201, 16'h0, 12'd8);
    check("ovf_one_cycle", 64'(overflow), 64'd0);
    for (int i = 2; i < 8; i++) drive(1'b0, 16'h4200 + 16'(i), 16'h0, 12'd8);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_count", 64'(ovf_cnt - o0), 64'd1);
    check("ovf_stall_hs", 64'(hs_cnt - h0), 64'd0);
    source_ready = 1'b1;
    drain("t4_drain", 200);
    check("t4_beats", 64'(hs_cnt - h0), 64'd16);

    // Zero-gap length switch, ignored starts, full-depth frame and single-point frame
    h0 = hs_cnt;
    o0 = ovf_cnt;
    frame(4, 12'd4, 16'h5000, 1'b1, -1, 1'b0);
    frame(8, 12'd8, 16'h5100, 1'b1, -1, 1'b0);
    drain("t5a_drain", 100);
    check("t5a_beats", 64'(hs_cnt - h0), 64'd12);
    drive(1'b1, 16'h5f00, 16'h0, 12'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h5f10 + 16'(i), 16'h0, 12'd0);
    drive(1'b1, 16'h5f20, 16'h0, 12'd17);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h5f30 + 16'(i), 16'h0, 12'd17);
    frame(16, 12'd16, 16'h5200, 1'b1, -1, 1'b0);
    frame(1, 12'd1, 16'h5300, 1'b1, -1, 1'b0);
    drain("t5b_drain", 200);
    check("t5_beats", 64'(hs_cnt - h0), 64'd29);
    check("t5_no_ovf", 64'(ovf_cnt - o0), 64'd0);

    // Reset while beat 3 is presented, then a normal frame
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        check("t6_pre_rst_beats", 64'(hs_cnt - h0), 64'd2);
        check("t6_beat3_valid", 64'(source_valid), 64'd1);
        rst_n_sync = 1'b0;
        exp_q.delete();
      end
      if (i == 6) rst_n_sync = 1'b1;
      if (i < 5) begin
        b.sop = (i == 0);
        b.eop = 1'b0;
        b.re  = 16'h6000 + 16'(i);
        b.im  = ~b.re;
        b.len = 12'd8;
        exp_q.push_back(b);
      end
      drive(i == 0, 16'h6000 + 16'(i), ~(16'h6000 + 16'(i)), 12'd8);
      if (i == 5) check_zero("t6_rst");
    end
    frame(4, 12'd4, 16'h6100, 1'b1, -1, 1'b0);
    drain("t6_drain", 100);
    check("t6_beats", 64'(hs_cnt - h0), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
